// File: rtl/scan_pkg.sv
// scan_pkg: mode encodings, FSM state constants and helpers shared by the scan mux sequencer
package scan_pkg;

    localparam logic [1:0] MODE_MANUAL   = 2'b00;
    localparam logic [1:0] MODE_CONT     = 2'b01;
    localparam logic [1:0] MODE_SINGLE   = 2'b10;
    localparam logic [1:0] MODE_RESERVED = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    function automatic logic is_sweep_mode(input logic [1:0] m);
        return (m == MODE_CONT) || (m == MODE_SINGLE);
    endfunction

    function automatic logic is_abort_mode(input logic [1:0] m);
        return (m == MODE_MANUAL) || (m == MODE_RESERVED);
    endfunction

endpackage

// File: rtl/dwell_ctr.sv
// dwell_ctr: loadable down-counter, expire is high while the count sits at zero
module dwell_ctr #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] load_val,
    output logic               expire
);
    logic [DWELL_W-1:0] count;

    assign expire = count == '0;

    // load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && !expire)
            count <= count - DWELL_W'(1);
    end

endmodule

// File: rtl/scan_mux_seq.sv
// scan_mux_seq: registered N:1 channel mux with manual select and built-in sweep sequencer
module scan_mux_seq
    import scan_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int DWELL_W  = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic                      start,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      sweep_done
);
    localparam logic [SEL_W:0]   CH_N     = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]   ch [CHANNELS];
    logic [0:0]         state;
    logic [SEL_W-1:0]   idx;
    logic               cont;
    logic [DWELL_W-1:0] dwell_m1;
    logic [DWELL_W-1:0] dwell_eff_m1;
    logic               sel_ok;
    logic               go;
    logic               sweeping;
    logic               expire;
    logic               last;

    genvar k;
    for (k = 0; k < CHANNELS; k++) begin : g_ch
        assign ch[k] = din[k*WIDTH +: WIDTH];
    end

    // dwell of 0 behaves as 1; the counter runs from D-1 down to 0
    assign dwell_eff_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign sel_ok       = {1'b0, sel_in} < CH_N;
    assign go           = (state == ST_IDLE) && start && is_sweep_mode(mode);
    assign sweeping     = (state == ST_SWEEP) && !is_abort_mode(mode);
    assign last         = sweeping && expire && (idx == LAST_IDX);

    dwell_ctr #(.DWELL_W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (go || (sweeping && expire)),
        .en       (sweeping),
        .load_val (go ? dwell_eff_m1 : dwell_m1),
        .expire   (expire)
    );

    // sequencer: launch latches dwell/mode, idx advances on dwell expiry, abort or single-end returns to idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cont     <= 1'b0;
            dwell_m1 <= '0;
        end else if (go) begin
            state    <= ST_SWEEP;
            idx      <= '0;
            cont     <= mode == MODE_CONT;
            dwell_m1 <= dwell_eff_m1;
        end else if (state == ST_SWEEP) begin
            if (!sweeping || (last && !cont))
                state <= ST_IDLE;
            if (sweeping && expire)
                idx <= (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
        end
    end

    // output register: sweep channel while sweeping, otherwise manual tracking of sel_in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            sel_out    <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            dout       <= sweeping ? ch[idx] : (sel_ok ? ch[sel_in] : '0);
            sel_out    <= sweeping ? idx : sel_in;
            out_valid  <= sweeping || sel_ok;
            busy       <= sweeping || go;
            sweep_done <= last;
        end
    end

endmodule

// File: tb/tb_scan_mux_seq.sv
// tb_scan_mux_seq: directed vectors with a cycle-count based reference model for scan_mux_seq
module tb_scan_mux_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic [1:0]  mode;
    logic [2:0]  sel_in;
    logic [7:0]  dwell;
    logic        start;
    logic [3:0]  dout, dout6;
    logic [2:0]  sel_out, sel_out6;
    logic        out_valid, busy, sweep_done;
    logic        out_valid6, busy6, sweep_done6;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    scan_mux_seq #(.WIDTH(4), .CHANNELS(8), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel_in(sel_in),
        .dwell(dwell), .start(start), .dout(dout), .sel_out(sel_out),
        .out_valid(out_valid), .busy(busy), .sweep_done(sweep_done)
    );

    scan_mux_seq #(.WIDTH(4), .CHANNELS(6), .DWELL_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .din(din[23:0]), .mode(mode), .sel_in(sel_in),
        .dwell(dwell), .start(start), .dout(dout6), .sel_out(sel_out6),
        .out_valid(out_valid6), .busy(busy6), .sweep_done(sweep_done6)
    );

    // reference: a sweep is "t output cycles since launch"; channel = (t/D) mod 8, done on last cycle of each lap
    bit         m_sw = 1'b0;
    bit         m_cont;
    int         m_t, m_d, m_idx;
    logic [3:0] e_dout = '0;
    logic [2:0] e_sel = '0;
    logic       e_val = 1'b0, e_busy = 1'b0, e_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sw = 1'b0;
            {e_dout, e_sel, e_val, e_busy, e_done} = '0;
        end else if (!m_sw || mode == 2'd0 || mode == 2'd3) begin
            e_dout = (sel_in < 8) ? 4'(din >> (4 * sel_in)) : 4'h0;
            e_sel  = sel_in;
            e_val  = sel_in < 8;
            e_done = 1'b0;
            if (m_sw) begin
                m_sw   = 1'b0;
                e_busy = 1'b0;
            end else if (start && (mode == 2'd1 || mode == 2'd2)) begin
                m_sw   = 1'b1;
                m_t    = 0;
                m_d    = (dwell == 0) ? 1 : int'(dwell);
                m_cont = mode == 2'd1;
                e_busy = 1'b1;
            end else begin
                e_busy = 1'b0;
            end
        end else begin
            m_idx  = (m_t / m_d) % 8;
            e_dout = 4'(din >> (4 * m_idx));
            e_sel  = 3'(m_idx);
            e_val  = 1'b1;
            e_busy = 1'b1;
            e_done = (m_t % (8 * m_d)) == (8 * m_d - 1);
            m_t++;
            if (e_done && !m_cont)
                m_sw = 1'b0;
        end
    end

    // every-cycle comparison of the 8-channel instance against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({dout, sel_out, out_valid, busy, sweep_done} !== {e_dout, e_sel, e_val, e_busy, e_done}) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t dout=%h want %h sel=%0d want %0d valid=%b want %b busy=%b want %b done=%b want %b",
                         $time, dout, e_dout, sel_out, e_sel, out_valid, e_val, busy, e_busy, sweep_done, e_done);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_dout"}, 32'(dout), 0);
        chk({nm, "_sel"}, 32'(sel_out), 0);
        chk({nm, "_valid"}, 32'(out_valid), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(sweep_done), 0);
    endtask

    int n_done, done_at;

    initial begin
        rst_n = 1'b0; din = 32'h7654_3210; mode = 2'd0; sel_in = 3'd0; dwell = 8'd0; start = 1'b0;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        chk_zero("por");
        rst_n = 1'b1;
        // manual select
        sel_in = 3'd5;
        @(negedge clk);
        chk("man5_dout", 32'(dout), 5);
        chk("man5_valid", 32'(out_valid), 1);
        chk("man5_dout6", 32'(dout6), 5);
        for (int s = 0; s < 8; s++) begin
            sel_in = 3'(s);
            @(negedge clk);
            chk("man_sweep_dout", 32'(dout), s);
            chk("ch6_valid", 32'(out_valid6), (s < 6) ? 1 : 0);
        end
        chk("ch6_oob_dout", 32'(dout6), 0);
        chk("ch6_oob_sel", 32'(sel_out6), 7);
        // reset in the middle of traffic
        sel_in = 3'd2;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk_zero("mid_rst");
        rst_n = 1'b1;
        // single sweep, dwell 3; dwell/mode edits mid-sweep must be ignored
        mode = 2'd2; dwell = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n_done = 0; done_at = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (sweep_done) begin n_done++; done_at = c; end
            if (c == 5) begin dwell = 8'd5; mode = 2'd1; end
            if (c == 1) chk("single_c1_sel", 32'(sel_out), 0);
            if (c == 3) chk("single_c3_sel", 32'(sel_out), 0);
            if (c == 4) chk("single_c4_dout", 32'(dout), 1);
            if (c == 24) chk("single_c24_dout", 32'(dout), 7);
            if (c == 24) chk("single_c24_busy", 32'(busy), 1);
            if (c == 25) chk("single_c25_busy", 32'(busy), 0);
        end
        chk("single_done_cnt", 32'(n_done), 1);
        chk("single_done_at", 32'(done_at), 24);
        // continuous sweep, dwell 0 acts as 1, start re-asserted mid-sweep
        mode = 2'd1; dwell = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n_done = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (sweep_done) n_done++;
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            if (c == 9) chk("cont_wrap_sel", 32'(sel_out), 0);
            if (c == 12) chk("cont_norestart_sel", 32'(sel_out), 3);
        end
        chk("cont_done_cnt", 32'(n_done), 2);
        // abort at channel 3
        mode = 2'd0; sel_in = 3'd6;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(sweep_done), 0);
        chk("abort_dout", 32'(dout), 6);
        // abort on the final dwell cycle suppresses sweep_done
        mode = 2'd1; dwell = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        chk("pre_final_sel", 32'(sel_out), 6);
        mode = 2'd3;
        @(negedge clk);
        chk("abort_final_done", 32'(sweep_done), 0);
        chk("abort_final_busy", 32'(busy), 0);
        // reset mid-sweep
        mode = 2'd2; dwell = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("sweep_busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("sweep_rst");
        rst_n = 1'b1;
        mode = 2'd0;
        @(negedge clk); @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
